// File: rtl/arp_pkg.sv
// Shared ARP constants and helpers used by the receive parser (and arp_send).
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN         = 8'h06;
  localparam logic [7:0]  ARP_PLEN         = 8'h04;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam int          ARP_WORDS        = 7;

  // Index of the final (TPA) word of the payload.
  localparam logic [2:0]  ARP_LAST_WORD    = 3'(ARP_WORDS - 1);

  typedef enum logic [0:0] {
    ST_RX      = 1'b0,
    ST_DISCARD = 1'b1
  } rx_state_e;

  // Only request and reply opcodes are accepted.
  function automatic logic oper_valid(input logic [15:0] oper);
    return (oper == ARP_OPER_REQUEST) || (oper == ARP_OPER_REPLY);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Next count: +1 unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {COUNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/arp_rx_parse.sv
// Receive-side ARP payload parser: validates fixed fields, feeds the ARP
// cache and raises a held reply request for requests aimed at local_ip_in.
module arp_rx_parse
  import arp_pkg::*;
#(
  parameter int COUNT_W   = 16,
  parameter bit LEARN_ALL = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        local_ip_in,
  input  logic [31:0]        arp_tdata_in,
  input  logic               arp_tvalid_in,
  input  logic [3:0]         arp_tkeep_in,
  input  logic               arp_tlast_in,
  output logic               arp_tready_out,
  output logic [31:0]        remote_ip_addr_out,
  output logic [47:0]        remote_mac_addr_out,
  output logic               reply_en_out,
  input  logic               reply_ack_in,
  output logic               cache_wr_en_out,
  output logic [31:0]        cache_ip_out,
  output logic [47:0]        cache_mac_out,
  output logic [COUNT_W-1:0] rx_ok_count_out,
  output logic [COUNT_W-1:0] rx_drop_count_out
);

  rx_state_e   state_q, state_d;
  logic [2:0]  word_cnt_q, word_cnt_d;
  logic        err_q, err_d;
  logic [15:0] oper_q, oper_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic        tready_q;
  logic        reply_en_q, reply_en_d;
  logic [31:0] remote_ip_q, remote_ip_d;
  logic [47:0] remote_mac_q, remote_mac_d;
  logic        cache_wr_q, cache_wr_d;
  logic [31:0] cache_ip_q, cache_ip_d;
  logic [47:0] cache_mac_q, cache_mac_d;

  logic beat_s, rx_beat_s, word_err_s, err_all_s, at_last_s;
  logic decide_s, tpa_match_s, qual_s, ack_clear_s, overrun_s;
  logic ok_inc_s, drop_inc_s;

  assign beat_s      = arp_tvalid_in & tready_q;
  assign rx_beat_s   = beat_s & (state_q == ST_RX);
  assign at_last_s   = (word_cnt_q == ARP_LAST_WORD);
  assign err_all_s   = err_q | word_err_s;
  assign tpa_match_s = (arp_tdata_in == local_ip_in);
  assign decide_s    = rx_beat_s & at_last_s & arp_tlast_in & ~err_all_s;
  assign qual_s      = decide_s & (oper_q == ARP_OPER_REQUEST) & tpa_match_s;
  assign ack_clear_s = reply_ack_in & reply_en_q;
  // A pending reply that is not being acked this cycle blocks a new one.
  assign overrun_s   = qual_s & reply_en_q & ~ack_clear_s;

  // Fixed-field checks on the beat currently presented.
  always_comb begin
    word_err_s = 1'b0;
    case (word_cnt_q)
      3'd0:    word_err_s = (arp_tdata_in != {ARP_HTYPE_ETH, ARP_PTYPE_IPV4});
      3'd1:    word_err_s = (arp_tdata_in[31:16] != {ARP_HLEN, ARP_PLEN}) ||
                            !oper_valid(arp_tdata_in[15:0]);
      default: word_err_s = 1'b0;
    endcase
    if (arp_tkeep_in != 4'hf) begin
      word_err_s = 1'b1;
    end else begin
      word_err_s = word_err_s;
    end
  end

  // Next-state logic: word position, error accumulation, discard of long packets.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_RX: begin
        if (!beat_s) begin
          state_d = ST_RX;
        end else if (arp_tlast_in) begin
          word_cnt_d = 3'd0;
          err_d      = 1'b0;
        end else if (at_last_s) begin
          state_d    = ST_DISCARD;
          word_cnt_d = 3'd0;
          err_d      = 1'b0;
        end else begin
          word_cnt_d = word_cnt_q + 3'd1;
          err_d      = err_all_s;
        end
      end
      ST_DISCARD: begin
        word_cnt_d = 3'd0;
        err_d      = 1'b0;
        if (beat_s && arp_tlast_in) begin
          state_d = ST_RX;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d    = ST_RX;
        word_cnt_d = 3'd0;
        err_d      = 1'b0;
      end
    endcase
  end

  // Output logic: field capture, decision, reply handshake and counter strobes.
  always_comb begin
    oper_d       = oper_q;
    sha_d        = sha_q;
    spa_d        = spa_q;
    reply_en_d   = reply_en_q;
    remote_ip_d  = remote_ip_q;
    remote_mac_d = remote_mac_q;
    cache_ip_d   = cache_ip_q;
    cache_mac_d  = cache_mac_q;

    if (rx_beat_s) begin
      case (word_cnt_q)
        3'd1: oper_d = arp_tdata_in[15:0];
        3'd2: sha_d[47:16] = arp_tdata_in;
        3'd3: begin
          sha_d[15:0]  = arp_tdata_in[31:16];
          spa_d[31:16] = arp_tdata_in[15:0];
        end
        3'd4: spa_d[15:0] = arp_tdata_in[31:16];
        default: oper_d = oper_q;
      endcase
    end else begin
      oper_d = oper_q;
    end

    cache_wr_d = decide_s & (LEARN_ALL | tpa_match_s);
    if (cache_wr_d) begin
      cache_ip_d  = spa_q;
      cache_mac_d = sha_q;
    end else begin
      cache_ip_d  = cache_ip_q;
      cache_mac_d = cache_mac_q;
    end

    // Ack clears first, so a coincident new request can relatch.
    if (ack_clear_s) begin
      reply_en_d = 1'b0;
    end else begin
      reply_en_d = reply_en_q;
    end
    if (qual_s && !overrun_s) begin
      reply_en_d   = 1'b1;
      remote_ip_d  = spa_q;
      remote_mac_d = sha_q;
    end else begin
      remote_ip_d  = remote_ip_q;
      remote_mac_d = remote_mac_q;
    end

    ok_inc_s   = decide_s & ~overrun_s;
    drop_inc_s = (rx_beat_s & arp_tlast_in & (~at_last_s | err_all_s)) |
                 (rx_beat_s & ~arp_tlast_in & at_last_s) |
                 overrun_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RX;
      word_cnt_q   <= 3'd0;
      err_q        <= 1'b0;
      oper_q       <= 16'h0000;
      sha_q        <= 48'h0;
      spa_q        <= 32'h0;
      tready_q     <= 1'b0;
      reply_en_q   <= 1'b0;
      remote_ip_q  <= 32'h0;
      remote_mac_q <= 48'h0;
      cache_wr_q   <= 1'b0;
      cache_ip_q   <= 32'h0;
      cache_mac_q  <= 48'h0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      err_q        <= err_d;
      oper_q       <= oper_d;
      sha_q        <= sha_d;
      spa_q        <= spa_d;
      tready_q     <= 1'b1;
      reply_en_q   <= reply_en_d;
      remote_ip_q  <= remote_ip_d;
      remote_mac_q <= remote_mac_d;
      cache_wr_q   <= cache_wr_d;
      cache_ip_q   <= cache_ip_d;
      cache_mac_q  <= cache_mac_d;
    end
  end

  sat_counter #(.COUNT_W(COUNT_W)) u_ok_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ok_inc_s),
    .count   (rx_ok_count_out)
  );

  sat_counter #(.COUNT_W(COUNT_W)) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (drop_inc_s),
    .count   (rx_drop_count_out)
  );

  assign arp_tready_out      = tready_q;
  assign remote_ip_addr_out  = remote_ip_q;
  assign remote_mac_addr_out = remote_mac_q;
  assign reply_en_out        = reply_en_q;
  assign cache_wr_en_out     = cache_wr_q;
  assign cache_ip_out        = cache_ip_q;
  assign cache_mac_out       = cache_mac_q;

endmodule
